// File: rtl/btn_pkg.sv
// Shared state encoding and sizing helper for the button event controller.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_ctrl.sv
// Turns a debounced button level into press/release/long/repeat strobes,
// a held level and a wrapping press counter; all outputs registered.
module button_event_ctrl
    import btn_pkg::*;
#(
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int REPEAT_CYCLES = 20_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_in,
    input  logic        repeat_en,
    output logic        press_pulse,
    output logic        release_pulse,
    output logic        long_pulse,
    output logic        repeat_pulse,
    output logic        held,
    output logic [15:0] press_count
);

    localparam int CW = $clog2(max_int(LONG_CYCLES, REPEAT_CYCLES));
    localparam logic [CW-1:0] LONG_TC = CW'(LONG_CYCLES - 1);
    localparam logic [CW-1:0] REP_TC  = CW'(REPEAT_CYCLES - 1);

    btn_state_t    r_state, w_state;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_press, r_rel, r_long, r_rep, r_held;
    logic          w_press, w_rel, w_long, w_rep, w_held;
    logic [15:0]   r_count, w_count;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
            r_rel   <= 1'b0;
            r_long  <= 1'b0;
            r_rep   <= 1'b0;
            r_held  <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_press <= w_press;
            r_rel   <= w_rel;
            r_long  <= w_long;
            r_rep   <= w_rep;
            r_held  <= w_held;
            r_count <= w_count;
        end
    end

    // Release is tested first so it beats a terminal count on the same edge.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_press = 1'b0;
        w_rel   = 1'b0;
        w_long  = 1'b0;
        w_rep   = 1'b0;
        w_count = r_count;
        case (r_state)
            ST_IDLE: begin
                if (btn_in) begin
                    w_state = ST_PRESSED;
                    w_cnt   = '0;
                    w_press = 1'b1;
                    w_count = r_count + 16'd1;
                end
            end
            ST_PRESSED: begin
                if (!btn_in) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                    w_rel   = 1'b1;
                end else if (r_cnt == LONG_TC) begin
                    w_state = ST_HELD;
                    w_cnt   = '0;
                    w_long  = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            ST_HELD: begin
                if (!btn_in) begin
                    w_state = ST_IDLE;
                    w_cnt   = '0;
                    w_rel   = 1'b1;
                end else if (!repeat_en) begin
                    w_cnt = '0;
                end else if (r_cnt == REP_TC) begin
                    w_cnt = '0;
                    w_rep = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_cnt   = '0;
            end
        endcase
        w_held = (w_state != ST_IDLE);
    end

    assign press_pulse   = r_press;
    assign release_pulse = r_rel;
    assign long_pulse    = r_long;
    assign repeat_pulse  = r_rep;
    assign held          = r_held;
    assign press_count   = r_count;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Randomized and directed bench for button_event_ctrl against a timing-based model.
module tb_button_event_ctrl;

    localparam int L = 8;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        btn_in = 1'b0;
    logic        repeat_en = 1'b0;
    logic        press_pulse, release_pulse, long_pulse, repeat_pulse, held;
    logic [15:0] press_count;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    button_event_ctrl #(.LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
        .clk(clk), .reset_n(reset_n), .btn_in(btn_in), .repeat_en(repeat_en),
        .press_pulse(press_pulse), .release_pulse(release_pulse),
        .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
        .held(held), .press_count(press_count)
    );

    always #5 clk = ~clk;

    // Model: time elapsed since press decides the long event, time since
    // the last long/repeat (with repeat enabled) decides the next repeat.
    bit          m_active, m_long_done;
    int          m_t, m_rt;
    bit          m_press, m_rel, m_long, m_rep;
    logic [15:0] m_cnt = '0;

    always @(posedge clk) begin
        cyc++;
        m_press = 0; m_rel = 0; m_long = 0; m_rep = 0;
        if (!reset_n) begin
            m_active = 0; m_long_done = 0; m_t = 0; m_rt = 0; m_cnt = '0;
        end else if (!m_active) begin
            if (btn_in) begin
                m_press = 1; m_active = 1; m_long_done = 0;
                m_t = 0; m_rt = 0; m_cnt = m_cnt + 16'd1;
            end
        end else if (!btn_in) begin
            m_rel = 1; m_active = 0;
        end else if (!m_long_done) begin
            m_t++;
            if (m_t == L) begin
                m_long = 1; m_long_done = 1; m_rt = 0;
            end
        end else if (repeat_en) begin
            m_rt++;
            if (m_rt == R) begin
                m_rep = 1; m_rt = 0;
            end
        end else begin
            m_rt = 0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, got, exp);
    endtask

    task automatic cmp_all();
        chk("press_pulse", 32'(press_pulse), 32'(m_press));
        chk("release_pulse", 32'(release_pulse), 32'(m_rel));
        chk("long_pulse", 32'(long_pulse), 32'(m_long));
        chk("repeat_pulse", 32'(repeat_pulse), 32'(m_rep));
        chk("held", 32'(held), 32'(m_active));
        chk("press_count", 32'(press_count), 32'(m_cnt));
        chk("one_hot_pulses", 32'(int'(press_pulse) + int'(release_pulse)
            + int'(long_pulse) + int'(repeat_pulse) <= 1), 32'd1);
    endtask

    // Called at a negedge: apply inputs, let one rising edge sample them,
    // then compare at the following negedge.
    task automatic tick(input logic b, input logic r, input logic rn);
        btn_in = b; repeat_en = r; reset_n = rn;
        @(negedge clk);
        cmp_all();
    endtask

    initial begin
        logic b, r, rn;
        int len;
        @(negedge clk);
        tick(0, 0, 0);
        tick(0, 0, 0);
        chk("reset_held", 32'(held), 32'd0);
        chk("reset_count", 32'(press_count), 32'd0);

        // Short press, 3 cycles high
        tick(1, 0, 1);
        chk("short_press", 32'(press_pulse), 32'd1);
        chk("short_held", 32'(held), 32'd1);
        tick(1, 0, 1);
        tick(1, 0, 1);
        chk("short_no_long", 32'(long_pulse), 32'd0);
        tick(0, 0, 1);
        chk("short_release", 32'(release_pulse), 32'd1);
        chk("short_held_low", 32'(held), 32'd0);
        chk("short_count", 32'(press_count), 32'd1);

        // Long hold, 20 cycles, repeat enabled
        tick(1, 1, 1);
        for (int i = 1; i < 20; i++) begin
            tick(1, 1, 1);
            chk("long_at_8", 32'(long_pulse), 32'(i == 8));
            chk("rep_at_12_16", 32'(repeat_pulse), 32'(i == 12 || i == 16));
        end
        tick(0, 1, 1);
        chk("long_release", 32'(release_pulse), 32'd1);

        // Release on the long terminal edge
        tick(1, 1, 1);
        for (int i = 1; i < 8; i++) tick(1, 1, 1);
        tick(0, 1, 1);
        chk("bound_release", 32'(release_pulse), 32'd1);
        chk("bound_no_long", 32'(long_pulse), 32'd0);

        // Repeat disabled in HELD, then re-enabled
        tick(1, 0, 1);
        for (int i = 1; i <= 8; i++) tick(1, 0, 1);
        chk("ren0_long", 32'(long_pulse), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick(1, 0, 1);
            chk("ren0_no_rep", 32'(repeat_pulse), 32'd0);
        end
        for (int i = 1; i <= 4; i++) begin
            tick(1, 1, 1);
            chk("ren1_rep_at_4", 32'(repeat_pulse), 32'(i == 4));
        end
        tick(0, 1, 1);

        // Reset mid-HELD with button kept high
        tick(1, 1, 1);
        for (int i = 0; i < 10; i++) tick(1, 1, 1);
        tick(1, 1, 0);
        chk("rst_no_release", 32'(release_pulse), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        chk("rst_count", 32'(press_count), 32'd0);
        tick(1, 1, 1);
        chk("rst_repress", 32'(press_pulse), 32'd1);
        chk("rst_repress_cnt", 32'(press_count), 32'd1);

        // Randomized segments with occasional reset
        r = 1'b0;
        for (int s = 0; s < 150; s++) begin
            b = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 24));
            for (int j = 0; j < len; j++) begin
                if ($urandom_range(0, 7) == 0) r = ~r;
                rn = ($urandom_range(0, 299) != 0);
                tick(b, r, rn);
            end
        end

        // Counter wrap: 65537 presses from reset
        tick(0, 0, 0);
        for (int i = 0; i < 65537; i++) begin
            tick(1, 0, 1);
            tick(0, 0, 1);
        end
        chk("wrap_count", 32'(press_count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/button_event_ctrl.md
BUTTON_EVENT_CTRL -- requirements
Module: button_event_ctrl

Interface
REQ-001 SHALL have parameter LONG_CYCLES, default 100_000_000: hold time, in clocks, to a long-press event (~1 s @ 100 MHz); legal range >= 2.
REQ-002 SHALL have parameter REPEAT_CYCLES, default 20_000_000: auto-repeat period, in clocks, after a long press (~200 ms); legal range >= 2.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port btn_in  input  1  debounced button level, 1 = pressed; synchronous to clk.
REQ-006 SHALL have port repeat_en  input  1  enables auto-repeat pulses while in HELD.
REQ-007 SHALL have port press_pulse  output  1  one-cycle strobe on press.
REQ-008 SHALL have port release_pulse  output  1  one-cycle strobe on release.
REQ-009 SHALL have port long_pulse  output  1  one-cycle strobe when hold reaches LONG_CYCLES.
REQ-010 SHALL have port repeat_pulse  output  1  one-cycle strobe every REPEAT_CYCLES in HELD.
REQ-011 SHALL have port held  output  1  level, high while state is PRESSED or HELD.
REQ-012 SHALL have port press_count  output  16  wrapping count of press events.

Function
REQ-013 SHALL implement FSM with states IDLE, PRESSED, HELD; all outputs registered.
REQ-014 IDLE with btn_in=1 at edge k SHALL go to PRESSED, clear the counter, and assert press_pulse for exactly the cycle after edge k.
REQ-015 press_count SHALL increment, modulo 2^16, at the same edge that sets press_pulse.
REQ-016 PRESSED with btn_in=1 SHALL increment the counter each edge; when counter == LONG_CYCLES-1, it SHALL assert long_pulse, clear the counter, and go to HELD. long_pulse therefore fires at edge k+LONG_CYCLES.
REQ-017 HELD with btn_in=1 and repeat_en=1 SHALL increment the counter; when counter == REPEAT_CYCLES-1, it SHALL assert repeat_pulse, clear the counter, and stay in HELD.
REQ-018 HELD with repeat_en=0 SHALL hold the counter at 0 and emit no repeat_pulse; re-enabling SHALL give the first repeat REPEAT_CYCLES edges later.
REQ-019 PRESSED or HELD with btn_in=0 SHALL assert release_pulse, clear the counter, and go to IDLE.
REQ-020 Release on the edge where the counter reaches terminal count SHALL win: release_pulse only, no long or repeat pulse.
REQ-021 At most one of press, release, long and repeat pulses SHALL be high in any cycle.
REQ-022 btn_in=1 in the cycle after release SHALL be a new press; there is no lockout.
REQ-023 Counter width SHALL be $clog2(max(LONG_CYCLES, REPEAT_CYCLES)); the counter SHALL never wrap.
REQ-024 held SHALL go high in the same cycle as press_pulse and low in the same cycle as release_pulse.

Reset
REQ-025 reset_n=0 sampled at a rising edge SHALL force IDLE, counter 0, all pulses 0, held 0, press_count 0.
REQ-026 Reset mid-hold SHALL emit no release_pulse; if btn_in=1 at the first edge after reset deasserts, a fresh press_pulse SHALL follow.

Structure
REQ-027 State encoding (IDLE=0, PRESSED=1, HELD=2) SHALL live in the shared package btn_pkg; parameter defaults stay local.
REQ-028 SHALL be a single module with no sub-module; the debouncer is instantiated upstream by the integrating top level.

Verification (LONG_CYCLES=8, REPEAT_CYCLES=4)
REQ-029 Short press: btn_in high 3 cycles -> press_pulse once, release_pulse once 3 cycles later, no long_pulse, press_count=1.
REQ-030 Long hold: btn_in high 20 cycles, repeat_en=1 -> long_pulse at press+8, repeat_pulse at press+12 and press+16, release at press+20.
REQ-031 Boundary: btn_in falls exactly 8 edges after press -> release_pulse only, long_pulse never asserts.
REQ-032 repeat_en=0 during HELD for 10 cycles -> no repeat_pulse; re-assert -> repeat_pulse 4 edges later.
REQ-033 Reset mid-HELD with btn_in kept high -> outputs and press_count zeroed, no release_pulse, press_pulse 1 cycle after reset release.
REQ-034 Wrap: 65,537 presses -> press_count=1, checked against a scoreboard reference model.
